nibble_demux: RTL

//  Receive end of the time-multiplexed 4-bit bus: takes the shared nibble w_in and the

---
 rtl/nibble_demux.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nibble_demux.sv
// Receive end of the time-multiplexed nibble bus: synchronises select and data, waits a
// settle window after each select edge, then captures the data or syndrome nibble.
module nibble_demux #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_in,
    input  logic [3:0] w_in,
    output logic [3:0] i_out,
    output logic [3:0] p_out,
    output logic       i_valid,
    output logic       p_valid,
    output logic       frame_valid,
    output logic       pair_changed,
    output logic       short_phase
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTLE_LO = 3'd1;
    localparam logic [2:0] HOLD_LO   = 3'd2;
    localparam logic [2:0] SETTLE_HI = 3'd3;
    localparam logic [2:0] HOLD_HI   = 3'd4;

    logic [SYNC_STAGES-1:0]      sel_sync_q;
    logic [SYNC_STAGES-1:0][3:0] w_sync_q;
    logic                        sel_q;
    logic [SYNC_STAGES:0]        arm_q;
    logic [2:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [3:0]                  i_q, i_d, p_q, p_d;
    logic                        iv_q, iv_d, pv_q, pv_d;
    logic                        fok_q, fok_d;
    logic                        have_q, have_d;
    logic [7:0]                  last_q, last_d;
    logic                        fv_q, fv_d, pc_q, pc_d, sp_q, sp_d;

    logic       sel_s;
    logic [3:0] w_s;
    logic       edge_det;

    assign sel_s = sel_sync_q[SYNC_STAGES-1];
    assign w_s   = w_sync_q[SYNC_STAGES-1];
    // The chains come out of reset at 0, so edges are ignored until sel_q holds a real
    // sample; a select already high at reset release is then not mistaken for an edge.
    assign edge_det = arm_q[SYNC_STAGES] && (sel_s != sel_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        p_d     = p_q;
        iv_d    = iv_q;
        pv_d    = pv_q;
        fok_d   = fok_q;
        have_d  = have_q;
        last_d  = last_q;
        fv_d    = 1'b0;
        pc_d    = 1'b0;
        sp_d    = 1'b0;
        case (state_q)
            IDLE, HOLD_LO, HOLD_HI: begin
                if (edge_det) begin
                    state_d = sel_s ? SETTLE_HI : SETTLE_LO;
                    cnt_d   = '0;
                end
            end
            SETTLE_LO, SETTLE_HI: begin
                if (edge_det) begin
                    sp_d    = 1'b1;
                    fok_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = sel_s ? SETTLE_HI : SETTLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    if (state_q == SETTLE_LO) begin
                        i_d     = w_s;
                        iv_d    = 1'b1;
                        fok_d   = 1'b1;
                        state_d = HOLD_LO;
                    end else begin
                        p_d     = w_s;
                        pv_d    = 1'b1;
                        fok_d   = 1'b0;
                        state_d = HOLD_HI;
                        if (fok_q) begin
                            fv_d   = 1'b1;
                            pc_d   = !have_q || ({i_q, w_s} != last_q);
                            last_d = {i_q, w_s};
                            have_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync_q <= '0;
            w_sync_q   <= '0;
            sel_q      <= 1'b0;
            arm_q      <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            i_q        <= '0;
            p_q        <= '0;
            iv_q       <= 1'b0;
            pv_q       <= 1'b0;
            fok_q      <= 1'b0;
            have_q     <= 1'b0;
            last_q     <= '0;
            fv_q       <= 1'b0;
            pc_q       <= 1'b0;
            sp_q       <= 1'b0;
        end else begin
            sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
            w_sync_q   <= {w_sync_q[SYNC_STAGES-2:0], w_in};
            sel_q      <= sel_s;
            arm_q      <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            p_q        <= p_d;
            iv_q       <= iv_d;
            pv_q       <= pv_d;
            fok_q      <= fok_d;
            have_q     <= have_d;
            last_q     <= last_d;
            fv_q       <= fv_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
        end
    end

    assign i_out        = i_q;
    assign p_out        = p_q;
    assign i_valid      = iv_q;
    assign p_valid      = pv_q;
    assign frame_valid  = fv_q;
    assign pair_changed = pc_q;
    assign short_phase  = sp_q;

endmodule
